fft_bfly_stage: RTL
===================

FFT_BFLY_STAGE -- requirements
Module: fft_bfly_stage

Interface
REQ-001 Parameter DW, default 32, width of each real/imag component, two's complement.
REQ-002 Parameter NPT, default 16, points per vector; power of two, 4..64.
REQ-003 Parameter SPAN, default 2, butterfly distance; legal values 1 or 2.
REQ-004 Port clk  input  1  sole clock, rising edge.
REQ-005 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 Port in_valid  input  1  in_data/in_scale/in_inv valid this cycle.
REQ-007 Port in_ready  output  1  block accepts input this cycle.
REQ-008 Port in_data  input  NPT*2*DW  point i at bits [(i+1)*2*DW-1 : i*2*DW]; real in upper DW, imag in lower DW.
REQ-009 Port in_scale  input  1  per-vector mode: 1 = divide results by 2.
REQ-010 Port in_inv  input  1  per-vector mode: 1 = +j rotation (IFFT), 0 = -j (FFT).
REQ-011 Port out_valid  output  1  out_data valid.
REQ-012 Port out_ready  input  1  downstream accepts out_data.
REQ-013 Port out_data  output  NPT*2*DW  result vector, same packing as in_data.
REQ-014 Port ovf  output  1  sticky overflow flag.
REQ-015 Port ovf_clr  input  1  synchronous clear of ovf.

Function
REQ-016 Points are grouped in blocks of 2*SPAN; for block base g and k in 0..SPAN-1: a = x[g+k], b = x[g+k+SPAN].
REQ-017 Sum output y[g+k] = a + b, on real and imag independently.
REQ-018 Difference d = a - b; y[g+k+SPAN] = d when k = 0.
REQ-019 When SPAN = 2 and k = 1: with in_inv = 0, y = (d.im, -d.re); with in_inv = 1, y = (-d.im, d.re).
REQ-020 All sums, differences and negations computed at DW+2 bits, sign-extended, before narrowing.
REQ-021 in_scale = 1: result = full-precision value arithmetic-shifted right by 1 (floor), then truncated to DW.
REQ-022 in_scale = 0: result = low DW bits (wrap-around); ovf sets if any component's full value lies outside [-2^(DW-1), 2^(DW-1)-1].
REQ-023 ovf stays set until ovf_clr = 1; if ovf_clr and a new overflow occur in the same cycle, ovf = 1.
REQ-024 Overflow is evaluated in stage 2 when the vector loads into the output register.
REQ-025 Two register stages: S1 holds the captured input vector and its mode bits; S2 holds computed results.
REQ-026 Transfer rules: input handshake when in_valid & in_ready; output handshake when out_valid & out_ready.
REQ-027 S2 loads when S1 valid and (S2 empty or output handshake); S1 loads on input handshake.
REQ-028 in_ready = !S1_valid | S2 load condition; full throughput, one vector per cycle without stall.
REQ-029 Latency: input handshake at cycle N gives out_valid at N+2 if out_ready stayed high.
REQ-030 out_data and out_valid stable while out_valid = 1 and out_ready = 0.
REQ-031 Mode bits travel with their vector; a mode change between consecutive vectors affects only the later vector.
REQ-032 Order preserved; no vector dropped or duplicated under any in_valid/out_ready pattern.

Reset
REQ-033 rst_n low asynchronously clears S1/S2 valid, out_valid = 0, ovf = 0, out_data = 0.
REQ-034 rst_n low mid-operation discards in-flight vectors; in_ready = 1 on the first cycle after release.

Verification (DW=32, NPT=16, SPAN=2, values as (re,im))
REQ-035 Butterfly: x0=(1,2) x1=(3,4) x2=(5,6) x3=(7,9), inv=0, scale=0 -> y0=(6,8) y1=(10,13) y2=(-4,-4) y3=(-5,4); every 4-point group matches.
REQ-036 IFFT mode: same vector with inv=1 -> y3=(5,-4); other outputs unchanged.
REQ-037 Overflow: x0.re=0x7FFFFFFF, x2.re=1, scale=0 -> y0.re=0x80000000, ovf=1 held until ovf_clr pulse; repeat with scale=1 -> y0.re=0x40000000, ovf stays 0.
REQ-038 Backpressure: stream 4 vectors, out_ready=0 for 3 cycles -> out_data held, in_ready=0 after S1 fills, all 4 emerge in order with no loss.
REQ-039 Throughput/latency: continuous in_valid, out_ready=1 -> first out_valid 2 cycles after first accept, then one vector per cycle.
REQ-040 Reset mid-stream: rst_n low with S1 and S2 full -> out_valid=0 and ovf=0 immediately; next vector after release emerges alone with correct result.

Source files
------------

// File: rtl/fft_bfly_stage.sv
// Radix-2 butterfly stage over a packed complex vector, with optional -j/+j twiddle
// on the second butterfly of each 4-point group and a two-register valid/ready pipeline.
module fft_bfly_stage #(
  parameter int DW   = 32,
  parameter int NPT  = 16,
  parameter int SPAN = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NPT*2*DW-1:0]   in_data,
  input  logic                  in_scale,
  input  logic                  in_inv,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [NPT*2*DW-1:0]   out_data,
  output logic                  ovf,
  input  logic                  ovf_clr
);

  localparam int VW = NPT * 2 * DW;
  localparam int CW = DW + 2;

  logic          s1_valid;
  logic [VW-1:0] s1_data;
  logic          s1_scale;
  logic          s1_inv;
  logic          s2_load;
  logic          in_fire;
  logic [VW-1:0] nxt_data;
  logic [NPT-1:0] pt_ovf;

  function automatic logic signed [CW-1:0] ext(input logic [DW-1:0] v);
    ext = {{2{v[DW-1]}}, v};
  endfunction

  // Top three bits of a CW-bit value all equal <=> the value fits in DW bits.
  function automatic logic out_of_range(input logic [2:0] t);
    out_of_range = !((&t) || !(|t));
  endfunction

  assign s2_load  = s1_valid && (!out_valid || out_ready);
  assign in_ready = !s1_valid || s2_load;
  assign in_fire  = in_valid && in_ready;

  for (genvar i = 0; i < NPT; i++) begin : g_pt
    localparam int P    = i % (2 * SPAN);
    localparam bit HI   = (P >= SPAN);
    localparam int IA   = HI ? i - SPAN : i;
    localparam int IB   = HI ? i : i + SPAN;
    localparam bit ROT  = HI && (SPAN == 2) && (P == 3);

    logic signed [CW-1:0] a_re, a_im, b_re, b_im, d_re, d_im, f_re, f_im;

    assign a_re = ext(s1_data[(2*IA+1)*DW +: DW]);
    assign a_im = ext(s1_data[(2*IA)*DW   +: DW]);
    assign b_re = ext(s1_data[(2*IB+1)*DW +: DW]);
    assign b_im = ext(s1_data[(2*IB)*DW   +: DW]);
    assign d_re = a_re - b_re;
    assign d_im = a_im - b_im;

    // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
    always_comb begin
      f_re = d_re;
      f_im = d_im;
      if (!HI) begin
        f_re = a_re + b_re;
        f_im = a_im + b_im;
      end else if (ROT) begin
        if (s1_inv) begin
          f_re = -d_im;
          f_im = d_re;
        end else begin
          f_re = d_im;
          f_im = -d_re;
        end
      end
    end

    // Scaling is an arithmetic shift by one (floor) followed by truncation to DW.
    assign nxt_data[(2*i+1)*DW +: DW] = s1_scale ? f_re[DW:1] : f_re[DW-1:0];
    assign nxt_data[(2*i)*DW   +: DW] = s1_scale ? f_im[DW:1] : f_im[DW-1:0];
    assign pt_ovf[i] = !s1_scale &&
                       (out_of_range(f_re[CW-1:DW-1]) || out_of_range(f_im[CW-1:DW-1]));
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  // NOTE: data registers are reset as well, since out_data must read zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_data   <= '0;
      s1_scale  <= 1'b0;
      s1_inv    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      ovf       <= 1'b0;
    end else begin
      if (in_fire) begin
        s1_valid <= 1'b1;
        s1_data  <= in_data;
        s1_scale <= in_scale;
        s1_inv   <= in_inv;
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end

      if (s2_load) begin
        out_valid <= 1'b1;
        out_data  <= nxt_data;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      // A new overflow wins over a simultaneous clear.
      ovf <= (ovf && !ovf_clr) || (s2_load && (|pt_ovf));
    end
  end

endmodule
